// File: rtl/data_mem_responder.sv
// Data-memory responder: word RAM plus MMIO window (console TX FIFO, halt register).
// Define RESPONDER_MTIMER_EN to build the 64-bit machine timer and its compare interrupt.
module data_mem_responder #(
  parameter int unsigned MEM_DEPTH_WORDS = 4096,
  parameter logic [31:0] MMIO_BASE       = 32'h1000_0000,
  parameter int unsigned CON_FIFO_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  input  logic [3:0]  data_we_i,
  output logic [31:0] data_rdata_o,
  output logic        con_valid_o,
  output logic [7:0]  con_data_o,
  input  logic        con_ready_i,
  output logic        timer_irq_o,
  output logic        halt_o,
  output logic [31:0] halt_code_o
);

  localparam int unsigned AW = $clog2(MEM_DEPTH_WORDS);
  localparam int unsigned PW = $clog2(CON_FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(CON_FIFO_DEPTH);

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] we);
    logic [31:0] r;
    r = old_v;
    for (int unsigned b = 0; b < 4; b++)
      if (we[b]) r[8*b +: 8] = new_v[8*b +: 8];
    return r;
  endfunction

  logic          is_mmio;
  logic [11:0]   off;
  logic [AW-1:0] ram_idx;
  logic          any_we;
  logic [31:0]   rdata;

  assign is_mmio = (data_addr_i[31:12] == MMIO_BASE[31:12]);
  assign off     = data_addr_i[11:0];
  assign ram_idx = data_addr_i[AW+1:2];
  assign any_we  = |data_we_i;

  // RAM: no reset, per-lane write at the clock edge, combinational read
  logic [31:0] mem [MEM_DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (!is_mmio && any_we)
      mem[ram_idx] <= merge(mem[ram_idx], data_wdata_i, data_we_i);
  end

  // Console TX FIFO
  logic [7:0]    fifo_mem [CON_FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          ovf;
  logic          pop, push_req, push_ok;

  assign pop      = (count != '0) && con_ready_i;
  assign push_req = is_mmio && (off == 12'h000) && data_we_i[0];
  assign push_ok  = push_req && ((count < DEPTH_C) || pop);

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= data_wdata_i[7:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      if (push_ok && !pop)      count <= count + CW'(1);
      else if (!push_ok && pop) count <= count - CW'(1);
      if (push_req && !push_ok) ovf <= 1'b1;
    end
  end

  assign con_valid_o = (count != '0);
  assign con_data_o  = con_valid_o ? fifo_mem[rd_ptr] : '0;

  // Halt register: only the first write is captured
  logic        halt_q;
  logic [31:0] halt_code_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      halt_q      <= 1'b0;
      halt_code_q <= '0;
    end else if (is_mmio && (off == 12'h018) && any_we && !halt_q) begin
      halt_q      <= 1'b1;
      halt_code_q <= merge('0, data_wdata_i, data_we_i);
    end
  end

  assign halt_o      = halt_q;
  assign halt_code_o = halt_code_q;

`ifdef RESPONDER_MTIMER_EN
  logic [63:0] mtime, mtimecmp;
  logic        irq_q;
  logic        wr_mt_lo, wr_mt_hi;

  assign wr_mt_lo = is_mmio && (off == 12'h008) && any_we;
  assign wr_mt_hi = is_mmio && (off == 12'h00C) && any_we;

  // Any write to either mtime half suppresses the increment for that cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mtime    <= '0;
      mtimecmp <= '1;
      irq_q    <= 1'b0;
    end else begin
      if (wr_mt_lo)      mtime[31:0]  <= merge(mtime[31:0], data_wdata_i, data_we_i);
      else if (wr_mt_hi) mtime[63:32] <= merge(mtime[63:32], data_wdata_i, data_we_i);
      else               mtime        <= mtime + 64'd1;
      if (is_mmio && (off == 12'h010) && any_we)
        mtimecmp[31:0] <= merge(mtimecmp[31:0], data_wdata_i, data_we_i);
      if (is_mmio && (off == 12'h014) && any_we)
        mtimecmp[63:32] <= merge(mtimecmp[63:32], data_wdata_i, data_we_i);
      irq_q <= (mtime >= mtimecmp);
    end
  end

  assign timer_irq_o = irq_q;
`else
  assign timer_irq_o = 1'b0;
`endif

  always_comb begin
    rdata = '0;
    if (is_mmio) begin
      case (off)
        12'h004: rdata = {16'b0, 8'(count), 5'b0, ovf, (count == '0), (count == DEPTH_C)};
        12'h018: rdata = {31'b0, halt_q};
`ifdef RESPONDER_MTIMER_EN
        12'h008: rdata = mtime[31:0];
        12'h00C: rdata = mtime[63:32];
        12'h010: rdata = mtimecmp[31:0];
        12'h014: rdata = mtimecmp[63:32];
`endif
        default: rdata = '0;
      endcase
    end else begin
      rdata = mem[ram_idx];
    end
  end

  assign data_rdata_o = rst ? rdata : '0;

endmodule
